// File: rtl/trap_controller.sv
// -----------------------------------------------------------------------------
// trap_controller
//
// Sequences synchronous exceptions, the machine timer interrupt and MRET at
// the pipeline commit point. It sits upstream of csr_file: it pulses
// exception_en / mret_en into it and reads back mtvec / mepc to redirect
// fetch. It also owns the pipeline flush for the whole trap entry/exit.
//
// Ports
//   clk                 system clock, rising edge
//   rst                 synchronous, active-high reset
//   commit_valid        commit slot holds a real instruction
//   commit_stall        commit stage stalled; nothing is accepted while high
//   commit_pc[31:0]     PC of the commit-stage instruction
//   fetch_misaligned    instruction-address-misaligned     (cause 0)
//   illegal_instr       illegal instruction                (cause 2)
//   is_ebreak           EBREAK                             (cause 3)
//   is_ecall            ECALL from M-mode                  (cause 11)
//   is_mret             MRET at commit
//   timer_irq           level-sensitive machine timer interrupt request
//   mie                 global interrupt enable (mstatus.MIE)
//   mtvec_in[31:0]      csr_file.mtvec_out
//   mepc_in[31:0]       csr_file.mepc_out
//   exception_en        registered one-cycle pulse to csr_file (TRAP state)
//   exception_pc[31:0]  PC latched at acceptance, held while idle
//   exception_cause     cause latched at acceptance, held while idle
//   mret_en             registered one-cycle pulse (MRET state)
//   flush               kill all in-flight instructions, including commit
//   pc_redirect_en      registered one-cycle fetch redirect
//   pc_redirect_target  registered redirect address
//   busy                high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module trap_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic        commit_stall,
  input  logic [31:0] commit_pc,
  input  logic        fetch_misaligned,
  input  logic        illegal_instr,
  input  logic        is_ebreak,
  input  logic        is_ecall,
  input  logic        is_mret,
  input  logic        timer_irq,
  input  logic        mie,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  output logic        exception_en,
  output logic [31:0] exception_pc,
  output logic [31:0] exception_cause,
  output logic        mret_en,
  output logic        flush,
  output logic        pc_redirect_en,
  output logic [31:0] pc_redirect_target,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_TRAP     = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;
  localparam logic [1:0] ST_MRET     = 2'd3;

  localparam logic [31:0] CAUSE_MISALIGNED = 32'h0000_0000;
  localparam logic [31:0] CAUSE_ILLEGAL    = 32'h0000_0002;
  localparam logic [31:0] CAUSE_EBREAK     = 32'h0000_0003;
  localparam logic [31:0] CAUSE_ECALL_M    = 32'h0000_000B;
  localparam logic [31:0] CAUSE_M_TIMER    = 32'h8000_0007;

  logic [1:0] state;
  logic [1:0] state_nxt;

  logic sync_exc;
  logic irq_take;
  logic trap_take;
  logic accept;
  logic accept_trap;
  logic accept_mret;

  // Cause encoding in priority order; only meaningful when a trap is taken.
  function automatic logic [31:0] sel_cause(
    input logic misaligned,
    input logic illegal,
    input logic ebreak,
    input logic ecall
  );
    logic [31:0] c;
    if (misaligned)   c = CAUSE_MISALIGNED;
    else if (illegal) c = CAUSE_ILLEGAL;
    else if (ebreak)  c = CAUSE_EBREAK;
    else if (ecall)   c = CAUSE_ECALL_M;
    else              c = CAUSE_M_TIMER;
    return c;
  endfunction

  // Direct mode only: the low two mode bits of mtvec are dropped.
  function automatic logic [31:0] vec_base(input logic [31:0] mtvec);
    return {mtvec[31:2], 2'b00};
  endfunction

  assign sync_exc  = fetch_misaligned | illegal_instr | is_ebreak | is_ecall;
  assign irq_take  = timer_irq & mie;
  assign trap_take = sync_exc | irq_take;

  // Acceptance only happens in IDLE. Gating with rst keeps flush quiet while
  // the block is being reset, even if the pipeline presents an event.
  assign accept      = (state == ST_IDLE) & ~rst & commit_valid & ~commit_stall &
                       (trap_take | is_mret);
  assign accept_trap = accept & trap_take;
  assign accept_mret = accept & ~trap_take;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept_trap)      state_nxt = ST_TRAP;
        else if (accept_mret) state_nxt = ST_MRET;
      end
      ST_TRAP:     state_nxt = ST_REDIRECT;
      ST_REDIRECT: state_nxt = ST_IDLE;
      ST_MRET:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // State and pulse outputs. Pulses are registered from the next state so
  // each one is high exactly for the cycle the FSM spends in its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      exception_en   <= 1'b0;
      mret_en        <= 1'b0;
      pc_redirect_en <= 1'b0;
    end else begin
      state          <= state_nxt;
      exception_en   <= (state_nxt == ST_TRAP);
      mret_en        <= (state_nxt == ST_MRET);
      pc_redirect_en <= (state_nxt == ST_REDIRECT) | (state_nxt == ST_MRET);
    end
  end

  // Trap record and redirect address. These are cleared on reset because
  // downstream logic treats their reset value as architecturally visible.
  // The trap vector is sampled on the TRAP cycle so an MTVEC write that
  // committed just before the trap has reached mtvec_in by then; the MRET
  // return address is sampled in the accept cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      exception_pc       <= 32'h0;
      exception_cause    <= 32'h0;
      pc_redirect_target <= 32'h0;
    end else begin
      if (accept_trap) begin
        exception_pc    <= commit_pc;
        exception_cause <= sel_cause(fetch_misaligned, illegal_instr,
                                     is_ebreak, is_ecall);
      end
      if (state == ST_TRAP)
        pc_redirect_target <= vec_base(mtvec_in);
      else if (accept_mret)
        pc_redirect_target <= mepc_in;
    end
  end

  // The combinational accept term blocks the faulting instruction's
  // writeback in the very cycle it is seen at commit.
  assign flush = accept | (state != ST_IDLE);
  assign busy  = (state != ST_IDLE);

endmodule
